// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: datapath width, multiply step count, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package mac_pkg;

    localparam int MAC_W     = 8;
    localparam int MUL_STEPS = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } mac_state_e;

endpackage

// File: rtl/eightbit_adder.sv
// 8-bit ripple-carry adder, the single shared arithmetic resource of the MAC unit.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i addends; sum_o = (a_i + b_i) mod 256; cout_o carry out of bit 7.
module eightbit_adder (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    logic carry;

    always_comb begin
        carry = 1'b0;
        sum_o = '0;
        for (int i = 0; i < 8; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/mac_sequencer.sv
// Shift-and-add multiply-accumulate controller sharing one 8-bit adder; emits a dot product every N_OPS pairs.
// Latency: pair accepted at t -> MUL t+1..t+8, ACC t+9, ready again (or result valid) at t+10.
// Backpressure: IN_READY only in IDLE; RESULT/OUT_VALID held in DONE until OUT_READY.
// Ports: CLK, RST_N (async active-low), CLR (sync abort); IN_VALID/IN_READY/A_IN/B_IN operand pair;
//        OUT_VALID/OUT_READY/RESULT dot product; BUSY in MUL/ACC; SAT saturation flag.
// Build option: define MAC_SAT_EN for saturating arithmetic; otherwise arithmetic wraps and SAT is 0.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int N_OPS = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [MAC_W-1:0] A_IN,
    input  logic [MAC_W-1:0] B_IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [MAC_W-1:0] RESULT,
    output logic             BUSY,
    output logic             SAT
);

    localparam int STEP_W = $clog2(MUL_STEPS);

    mac_state_e        state_q, state_d;
    logic [MAC_W-1:0]  a_q, a_d;
    logic [MAC_W-1:0]  b_q, b_d;
    logic [MAC_W-1:0]  prod_q, prod_d;
    logic [MAC_W-1:0]  acc_q, acc_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [MAC_W-1:0]  add_a, add_b, add_sum;
    logic              add_cout_unused;
    logic [MAC_W-1:0]  a_shift;
    logic [MAC_W-1:0]  partial;

    // Bits of A shifted beyond bit 7 are simply lost in the wrapping datapath.
    assign a_shift = a_q << step_q;
    assign partial = b_q[step_q] ? a_shift : '0;

`ifdef MAC_SAT_EN
    logic                 sat_q, sat_d;
    logic [2*MAC_W-1:0]   a_wide;
    logic                 drop_nz;

    // A set multiplier bit that pushes nonzero multiplicand bits past bit 7 means the true product exceeds 255.
    assign a_wide  = {{MAC_W{1'b0}}, a_q} << step_q;
    assign drop_nz = b_q[step_q] && ((a_wide >> MAC_W) != '0);
`endif

    eightbit_adder u_adder (
        .a_i    (add_a),
        .b_i    (add_b),
        .sum_o  (add_sum),
        .cout_o (add_cout_unused)
    );

    // Operand mux for the shared adder, selected purely by state.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state_q)
            S_MUL: begin
                add_a = prod_q;
                add_b = partial;
            end
            S_ACC: begin
                add_a = acc_q;
                add_b = prod_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        step_d  = step_q;
        count_d = count_q;
`ifdef MAC_SAT_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    a_d     = A_IN;
                    b_d     = B_IN;
                    prod_d  = '0;
                    step_d  = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                prod_d = add_sum;
`ifdef MAC_SAT_EN
                // Once prod is 8'hFF any further nonzero partial overflows, so saturation is self-sustaining.
                if ((add_sum < prod_q) || drop_nz) begin
                    prod_d = '1;
                    sat_d  = 1'b1;
                end
`endif
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(MUL_STEPS - 1)) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_d = add_sum;
`ifdef MAC_SAT_EN
                if (add_sum < acc_q) begin
                    acc_d = '1;
                    sat_d = 1'b1;
                end
`endif
                count_d = count_q + CNT_W'(1);
                state_d = (count_q == CNT_W'(N_OPS - 1)) ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (OUT_READY) begin
                    acc_d   = '0;
                    count_d = '0;
`ifdef MAC_SAT_EN
                    sat_d   = 1'b0;
`endif
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over any handshake in the same cycle.
        if (CLR) begin
            state_d = S_IDLE;
            a_d     = '0;
            b_d     = '0;
            prod_d  = '0;
            acc_d   = '0;
            step_d  = '0;
            count_d = '0;
`ifdef MAC_SAT_EN
            sat_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            count_q <= count_d;
        end
    end

`ifdef MAC_SAT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
    assign SAT = sat_q;
`else
    assign SAT = 1'b0;
`endif

    assign IN_READY  = (state_q == S_IDLE);
    assign OUT_VALID = (state_q == S_DONE);
    assign RESULT    = (state_q == S_DONE) ? acc_q : '0;
    assign BUSY      = (state_q == S_MUL) || (state_q == S_ACC);

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: directed scenarios plus random dot products against an arithmetic model.
// Latency: n/a.
// Backpressure: exercised by holding OUT_READY low in DONE.
module tb_mac_sequencer;

    localparam int N = 4;

    logic       CLK = 1'b0;
    logic       RST_N, CLR, IN_VALID, IN_READY, OUT_VALID, OUT_READY, BUSY, SAT;
    logic [7:0] A_IN, B_IN, RESULT;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int unsigned qa[$];
    int unsigned qb[$];

    always #5 CLK = ~CLK;

    mac_sequencer #(.N_OPS(N), .CNT_W(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CLR       (CLR),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A_IN      (A_IN),
        .B_IN      (B_IN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RESULT    (RESULT),
        .BUSY      (BUSY),
        .SAT       (SAT)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: true products summed, either wrapped mod 256 or clamped at 255 at every stage.
    function automatic void ref_dot(output logic [7:0] r, output logic s);
        int unsigned acc;
        int unsigned p;
        acc = 0;
        s   = 1'b0;
        foreach (qa[i]) begin
            p = qa[i] * qb[i];
`ifdef MAC_SAT_EN
            if (p > 255) begin p = 255; s = 1'b1; end
            acc = acc + p;
            if (acc > 255) begin acc = 255; s = 1'b1; end
`else
            acc = (acc + p) % 256;
`endif
        end
        r = acc[7:0];
    endfunction

    task automatic reset_checks(input string tag);
        check({tag, "_in_ready"},  IN_READY,  1);
        check({tag, "_out_valid"}, OUT_VALID, 0);
        check({tag, "_result"},    RESULT,    0);
        check({tag, "_busy"},      BUSY,      0);
        check({tag, "_sat"},       SAT,       0);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (IN_READY !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (IN_READY !== 1'b1) check({tag, "_ready_timeout"}, IN_READY, 1);
    endtask

    task automatic accept_pair(input logic [7:0] a, input logic [7:0] b);
        wait_ready("accept");
        IN_VALID = 1'b1;
        A_IN     = a;
        B_IN     = b;
        step();
        IN_VALID = 1'b0;
        A_IN     = 8'($urandom);
        B_IN     = 8'($urandom);
    endtask

    // Accepts one pair and walks it through MUL/ACC, throwing junk (ignored) requests at the busy DUT.
    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input bit last);
        accept_pair(a, b);
        qa.push_back(a);
        qb.push_back(b);
        check("mul_busy", BUSY, 1);
        for (int k = 1; k <= 8; k++) begin
            IN_VALID = 1'($urandom_range(0, 1));
            A_IN     = 8'($urandom);
            B_IN     = 8'($urandom);
            step();
        end
        check("acc_busy", BUSY, 1);
        check("acc_in_ready", IN_READY, 0);
        check("acc_out_valid", OUT_VALID, 0);
        step();
        IN_VALID = 1'b0;
        check("t10_out_valid", OUT_VALID, last);
        check("t10_in_ready", IN_READY, !last);
        check("t10_busy", BUSY, 0);
    endtask

    task automatic finish_dot(input string tag, input int hold);
        logic [7:0] er;
        logic       es;
        logic [7:0] first;
        int         n;
        ref_dot(er, es);
        n = 0;
        while (OUT_VALID !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check({tag, "_out_valid"}, OUT_VALID, 1);
        check({tag, "_result"}, RESULT, er);
        check({tag, "_sat"}, SAT, es);
        first = RESULT;
        for (int i = 0; i < hold; i++) begin
            IN_VALID = 1'b1;
            A_IN     = 8'($urandom);
            B_IN     = 8'($urandom);
            step();
            check({tag, "_hold_valid"}, OUT_VALID, 1);
            check({tag, "_hold_result"}, RESULT, first);
            check({tag, "_hold_in_ready"}, IN_READY, 0);
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        check({tag, "_drain_valid"}, OUT_VALID, 0);
        check({tag, "_drain_ready"}, IN_READY, 1);
        check({tag, "_drain_sat"}, SAT, 0);
        qa.delete();
        qb.delete();
    endtask

    task automatic run_dot(input string tag, input logic [7:0] a[N], input logic [7:0] b[N], input int hold);
        for (int i = 0; i < N; i++) send_pair(a[i], b[i], i == N - 1);
        finish_dot(tag, hold);
    endtask

    initial begin
        logic [7:0] va[N];
        logic [7:0] vb[N];
        int bad;

        RST_N     = 1'b0;
        CLR       = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        A_IN      = '0;
        B_IN      = '0;
        #1;
        reset_checks("reset");
        step();
        step();
        RST_N = 1'b1;
        step();
        reset_checks("post_reset");

        // Basic dot product: 15+14+10+0 = 39, with 5 cycles of result backpressure.
        va = '{8'd3, 8'd2, 8'd10, 8'd0};
        vb = '{8'd5, 8'd7, 8'd1, 8'd200};
        run_dot("basic", va, vb, 5);

        // Overflowing products/sums: wraps to 0x2C or saturates to 0xFF.
        va = '{8'd16, 8'd200, 8'd100, 8'd1};
        vb = '{8'd16, 8'd1, 8'd1, 8'd0};
        run_dot("wrap", va, vb, 1);

        // Abort mid-multiply after one complete pair.
        send_pair(8'd7, 8'd9, 1'b0);
        accept_pair(8'd5, 8'd5);
        step();
        step();
        step();
        check("clr_busy_before", BUSY, 1);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        reset_checks("clr");
        qa.delete();
        qb.delete();

        // CLR must beat a simultaneous IN_VALID.
        CLR      = 1'b1;
        IN_VALID = 1'b1;
        step();
        CLR      = 1'b0;
        IN_VALID = 1'b0;
        check("clr_prio_busy", BUSY, 0);
        check("clr_prio_ready", IN_READY, 1);

        // Async reset in the middle of ACC.
        send_pair(8'd2, 8'd2, 1'b0);
        accept_pair(8'd3, 8'd3);
        for (int k = 0; k < 8; k++) step();
        check("rst_acc_busy", BUSY, 1);
        #2;
        RST_N = 1'b0;
        #1;
        reset_checks("rst_mid_acc");
        step();
        RST_N = 1'b1;
        qa.delete();
        qb.delete();

        va = '{8'd1, 8'd1, 8'd1, 8'd1};
        vb = '{8'd1, 8'd1, 8'd1, 8'd1};
        run_dot("after_abort", va, vb, 0);

        // IN_VALID held high with (255,255): ready pulses exactly every 10 cycles.
        for (int i = 0; i < N; i++) begin
            qa.push_back(255);
            qb.push_back(255);
        end
        IN_VALID = 1'b1;
        A_IN     = 8'd255;
        B_IN     = 8'd255;
        bad      = 0;
        for (int i = 0; i < 10 * N; i++) begin
            if (IN_READY !== ((i % 10) == 0)) bad++;
            step();
        end
        IN_VALID = 1'b0;
        check("cont_ready_pattern", bad, 0);
        check("cont_out_valid_t40", OUT_VALID, 1);
        finish_dot("cont", 0);

        // Random dot products.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                va[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
                vb[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            end
            run_dot("rand", va, vb, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Sequential multiply-accumulate controller for the MAC unit.
- Time-multiplexes one 8-bit ripple adder (eightbit_adder, carry-out discarded) to do shift-and-add multiplication of an operand pair, then adds the product into the accumulator.
- After N_OPS pairs it presents the 8-bit dot-product result on a valid/ready output.
- Sits between the operand source and the result consumer of the MAC unit.

Parameters:
N_OPS, 4, operand pairs per dot product (1..255)
CNT_W, 8, width of pair counter; must hold N_OPS

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous, active-low reset
CLR  input  1  synchronous clear/abort, highest priority after reset
IN_VALID  input  1  operand pair valid
IN_READY  output  1  sequencer accepts pair this cycle
A_IN  input  8  multiplicand, unsigned
B_IN  input  8  multiplier, unsigned
OUT_VALID  output  1  RESULT valid
OUT_READY  input  1  consumer takes RESULT
RESULT  output  8  accumulated dot product
BUSY  output  1  high in MUL or ACC
SAT  output  1  saturation occurred in current dot product; 0 without MAC_SAT_EN

Behaviour:
- Reset (RST_N=0, async): state IDLE; acc, prod, step, count = 0. Outputs: IN_READY=1, OUT_VALID=0, RESULT=0, BUSY=0, SAT=0.
- States: IDLE, MUL, ACC, DONE.
- IDLE: IN_READY=1. On IN_VALID: latch A_IN, B_IN; prod=0; step=0; go to MUL.
- MUL: 8 cycles, step 0..7.
  - Adder inputs: prod and (B[step] ? (A<<step)[7:0] : 0); prod <= sum.
  - After step 7, go to ACC.
- ACC: 1 cycle. Adder inputs: acc and prod; acc <= sum; count++.
  - If count+1 == N_OPS, go to DONE; else go to IDLE.
- DONE: OUT_VALID=1, RESULT=acc, held stable while OUT_READY=0; IN_READY=0.
  - On OUT_READY: acc=0, count=0, SAT=0; go to IDLE.
- Single adder instance; operand mux selected by state only. Adder inputs are 0 in IDLE and DONE.
- Arithmetic is modulo 2^8: product bits shifted past bit 7 and adder carry-out are dropped.
- Timing:
  - Pair accepted at cycle t → MUL t+1..t+8, ACC t+9.
  - Next IN_READY at t+10; throughput is one pair per 10 cycles.
  - For the last pair, OUT_VALID rises at t+10.
- BUSY = (state==MUL || state==ACC).
- CLR=1 from any state: same values as reset at the next edge. An in-flight pair is discarded and OUT_VALID drops.
- CLR takes priority over simultaneous IN_VALID or OUT_READY.
- IN_VALID while IN_READY=0 is ignored; the source must hold its data.
- A_IN/B_IN changes after acceptance have no effect.
- N_OPS=1: every accepted pair produces a result.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined (saturating arithmetic):
  - In MUL, prod is forced to 8'hFF if any adder overflow occurs (sum < prod, unsigned) or a set B bit drops nonzero shifted-out A bits. Once forced, it stays 8'hFF.
  - In ACC, overflow (sum < acc) sets acc=8'hFF.
  - Any saturation sets SAT, which is sticky until DONE handshake, CLR or reset.
- Undefined: wrap-around arithmetic; SAT tied 0; no saturation logic synthesized.

Decomposition:
- Shared package/header mac_pkg: MAC_W=8, MUL_STEPS=8, state encoding (IDLE=2'd0, MUL=2'd1, ACC=2'd2, DONE=2'd3).
- Sub-module: the existing eightbit_adder, instantiated once as the shared datapath. FSM, mux and registers stay in mac_sequencer.

Test Plan:
- N_OPS=4, pairs (3,5),(2,7),(10,1),(0,200) → RESULT=8'h27 (39), SAT=0; OUT_VALID exactly 10 cycles after the 4th accept.
- Wrap, macro off: pairs (16,16),(200,1),(100,1),(1,0) → products 0,200,100,0; RESULT=8'h2C; SAT=0.
- Same stimulus, MAC_SAT_EN on → first product 8'hFF, RESULT=8'hFF, SAT=1.
- Backpressure: hold OUT_READY=0 for 5 cycles in DONE → RESULT and OUT_VALID stable, IN_READY=0, IN_VALID ignored. Then OUT_READY=1 → IDLE, acc=0.
- Pulse CLR at MUL step 3, then RST_N low mid-ACC on a later pair → outputs return to reset values. Next dot product (1,1)x4 gives RESULT=8'h04.
- IN_VALID held continuously with constant (255,255) → IN_READY pulses every 10 cycles; each product is 8'h01 (mod 256); RESULT=8'h04.
